// File: rtl/pipe_pkg.sv
// pipe_pkg: shared stage-register state encoding, MIPS stage payload widths and bubble encoding
package pipe_pkg;
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b10
    } pipe_state_t;

    localparam int IF_ID_W  = 64;
    localparam int ID_EX_W  = 147;
    localparam int EX_MEM_W = 107;
    localparam int MEM_WB_W = 71;

    // sll $0,$0,0 -- the canonical MIPS bubble
    localparam logic [31:0] MIPS_NOP = 32'h0000_0000;
endpackage

// File: rtl/dffe_param.sv
// dffe_param: WIDTH-wide load-enabled register with async active-low clear to a parameter value
module dffe_param #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             nClear,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge nClear)
        if (!nClear) q <= RESET_VAL;
        else if (en) q <= d;
endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: valid/ready pipeline stage register with two-entry skid buffer and synchronous flush
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter logic [WIDTH-1:0] FLUSH_VAL = WIDTH'(MIPS_NOP)
) (
    input  logic             clk,
    input  logic             nClear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [1:0]       count
);
    pipe_state_t      state;
    logic [WIDTH-1:0] skid;
    logic             in_fire, out_fire, main_en, skid_en;
    logic [WIDTH-1:0] main_d, skid_d;

    assign out_valid = (state == ONE) || (state == TWO);
    assign count     = (state == TWO) ? 2'd2 : (state == ONE) ? 2'd1 : 2'd0;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // in_ready is held in its own flop so out_ready never reaches it combinationally
    always_ff @(posedge clk or negedge nClear)
        if (!nClear) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else if (flush) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            case (state)
                EMPTY: if (in_fire) state <= ONE;
                ONE:
                    if (in_fire && !out_fire) begin
                        state    <= TWO;
                        in_ready <= 1'b0;
                    end else if (!in_fire && out_fire) state <= EMPTY;
                TWO:
                    if (out_fire) begin
                        state    <= ONE;
                        in_ready <= 1'b1;
                    end
                default: begin
                    state    <= EMPTY;
                    in_ready <= 1'b1;
                end
            endcase
        end

    assign main_en = flush | (state == EMPTY && in_fire) | (state == ONE && in_fire && out_fire)
                   | (state == TWO && out_fire);
    assign main_d  = flush ? FLUSH_VAL : (state == TWO) ? skid : in_data;
    assign skid_en = flush | (state == ONE && in_fire && !out_fire);
    assign skid_d  = flush ? FLUSH_VAL : in_data;

    dffe_param #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
        .clk(clk), .nClear(nClear), .en(main_en), .d(main_d), .q(out_data)
    );

    dffe_param #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
        .clk(clk), .nClear(nClear), .en(skid_en), .d(skid_d), .q(skid)
    );
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed checks on a 16-bit stage and a randomized reference-queue run on a 32-bit stage
module tb_pipe_skid_reg;
    logic        clk = 1'b0;
    logic        nClear = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready, out_valid;
    logic [15:0] out_data;
    logic [1:0]  count;

    logic        r_in_valid = 1'b0, r_out_ready = 1'b0, r_flush = 1'b0;
    logic [31:0] r_in_data = '0;
    logic        r_in_ready, r_out_valid;
    logic [31:0] r_out_data;
    logic [1:0]  r_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipe_skid_reg #(.WIDTH(16), .RESET_VAL(16'h5A5A), .FLUSH_VAL(16'h0000)) u16 (
        .clk(clk), .nClear(nClear), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .flush(flush), .count(count)
    );

    pipe_skid_reg #(.WIDTH(32)) u32 (
        .clk(clk), .nClear(nClear), .in_valid(r_in_valid), .in_ready(r_in_ready), .in_data(r_in_data),
        .out_valid(r_out_valid), .out_ready(r_out_ready), .out_data(r_out_data), .flush(r_flush),
        .count(r_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic v, input logic r, input logic [1:0] c);
        check({tag, "_out_valid"}, 32'(out_valid), 32'(v));
        check({tag, "_in_ready"}, 32'(in_ready), 32'(r));
        check({tag, "_count"}, 32'(count), 32'(c));
    endtask

    task automatic push(input logic [15:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    logic [31:0] q[$];
    bit          fire_in, fire_out;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_state("reset", 1'b0, 1'b1, 2'd0);
        check("reset_data", 32'(out_data), 32'h5A5A);
        nClear = 1'b1;

        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(i);
            step();
            check("stream_data", 32'(out_data), 32'(i));
            check_state("stream", 1'b1, 1'b1, 2'd1);
        end
        in_valid = 1'b0;
        step();
        check_state("stream_end", 1'b0, 1'b1, 2'd0);

        out_ready = 1'b0;
        push(16'hAAAA);
        check_state("skid1", 1'b1, 1'b1, 2'd1);
        check("skid1_data", 32'(out_data), 32'hAAAA);
        push(16'hBBBB);
        check_state("skid2", 1'b1, 1'b0, 2'd2);
        check("skid2_data", 32'(out_data), 32'hAAAA);
        push(16'hDDDD);
        check_state("skid_full", 1'b1, 1'b0, 2'd2);
        check("skid_hold", 32'(out_data), 32'hAAAA);
        out_ready = 1'b1;
        step();
        check_state("drain1", 1'b1, 1'b1, 2'd1);
        check("drain1_data", 32'(out_data), 32'hBBBB);
        step();
        check_state("drain2", 1'b0, 1'b1, 2'd0);

        out_ready = 1'b0;
        push(16'h1111);
        push(16'h2222);
        check_state("pre_flush", 1'b1, 1'b0, 2'd2);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'hCCCC;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_state("flush", 1'b0, 1'b1, 2'd0);
        check("flush_data", 32'(out_data), 32'h0000);
        out_ready = 1'b1;
        repeat (2) begin
            step();
            check_state("post_flush", 1'b0, 1'b1, 2'd0);
            check("post_flush_data", 32'(out_data), 32'h0000);
        end

        out_ready = 1'b0;
        push(16'h3333);
        push(16'h4444);
        check_state("pre_reset", 1'b1, 1'b0, 2'd2);
        #2 nClear = 1'b0;
        #1;
        check_state("async_reset", 1'b0, 1'b1, 2'd0);
        check("async_reset_data", 32'(out_data), 32'h5A5A);
        nClear = 1'b1;
        push(16'h7777);
        check_state("after_reset", 1'b1, 1'b1, 2'd1);
        check("after_reset_data", 32'(out_data), 32'h7777);

        for (int c = 0; c < 10000; c++) begin
            check("r_out_valid", 32'(r_out_valid), 32'(q.size() != 0));
            check("r_in_ready", 32'(r_in_ready), 32'(q.size() < 2));
            check("r_count", 32'(r_count), 32'(q.size()));
            if (q.size() != 0) check("r_out_data", r_out_data, q[0]);
            r_in_valid  = $urandom_range(0, 3) != 0;
            r_in_data   = $urandom;
            r_out_ready = $urandom_range(0, 2) != 0;
            r_flush     = $urandom_range(0, 24) == 0;
            fire_in     = r_in_valid && q.size() < 2;
            fire_out    = r_out_ready && q.size() != 0;
            if (r_flush) q.delete();
            else begin
                if (fire_out) void'(q.pop_front());
                if (fire_in) q.push_back(r_in_data);
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
